mmio_timer: RTL and testbench

Memory-mapped 64-bit machine timer for the furv SoC bus. It sits beside the RAM, LED and UART decoders on the core's data port and shares the same `mem_en`/`mem_write`/`addr`/`read_ack` handshake. It provides a prescaled `mtime` counter, a 64-bit `mtimecmp` compare register and a level interrupt flag. Its read data and ack feed the top-level `data_in`/`read_ack` muxes.

---
 rtl/mmio_timer.sv | 125 ++++++++++++
 tb/tb_mmio_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer: prescaled mtime, 64-bit mtimecmp,
// sticky match flag and a level interrupt, on the core's shared data-port handshake.
module mmio_timer #(
  parameter int BASE     = 1056,
  parameter int PRESCALE = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        read_ack,
  output logic        irq
);

  localparam logic [31:0] BASE_W  = BASE;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;

  logic [63:0] mtime, mtimecmp;
  logic [31:0] hi_shadow;
  logic [15:0] pre;
  logic        en, irq_en, pending;

  logic        sel, wr, rd, tick, mt_wr, stop_wr, match;
  logic [2:0]  off;
  logic [31:0] rd_mux;

  // Byte lanes are not decoded; every access is treated as a full word.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign sel     = (addr[31:5] == BASE_W[31:5]);
  assign off     = addr[4:2];
  assign wr      = mem_en & mem_write & sel;
  assign rd      = mem_en & ~mem_write & sel;
  assign tick    = en && (pre == PRE_MAX);
  assign mt_wr   = wr && (off == OFF_MTIME_LO || off == OFF_MTIME_HI);
  assign stop_wr = wr && (off == OFF_CTRL) && !wdata[0];
  assign match   = (mtime >= mtimecmp);
  assign irq     = pending & irq_en;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_MTIME_LO: rd_mux = mtime[31:0];
      OFF_MTIME_HI: rd_mux = hi_shadow;
      OFF_CMP_LO:   rd_mux = mtimecmp[31:0];
      OFF_CMP_HI:   rd_mux = mtimecmp[63:32];
      OFF_CTRL:     rd_mux = {30'd0, irq_en, en};
      OFF_STATUS:   rd_mux = {31'd0, pending};
      default:      rd_mux = '0;
    endcase
  end

  // Prescaler restarts from zero on any mtime write or when counting stops,
  // so the first increment after enabling lands PRESCALE cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pre <= '0;
    else if (mt_wr || stop_wr || !en) pre <= '0;
    else if (pre == PRE_MAX)          pre <= '0;
    else                              pre <= pre + 16'd1;
  end

  // A software write to either half wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (mt_wr) begin
      if (off == OFF_MTIME_LO) mtime[31:0]  <= wdata;
      else                     mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
      en       <= 1'b0;
      irq_en   <= 1'b0;
    end else if (wr) begin
      case (off)
        OFF_CMP_LO: mtimecmp[31:0]  <= wdata;
        OFF_CMP_HI: mtimecmp[63:32] <= wdata;
        OFF_CTRL: begin
          en     <= wdata[0];
          irq_en <= wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Set has priority over a same-cycle software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         pending <= 1'b0;
    else if (match)                                  pending <= 1'b1;
    else if (wr && off == OFF_STATUS && wdata[0])    pending <= 1'b0;
  end

  // Reading MTIME_LO snapshots the upper half so a LO-then-HI pair is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_shadow <= '0;
      rdata     <= '0;
      read_ack  <= 1'b0;
    end else begin
      read_ack <= rd;
      if (rd) begin
        rdata <= rd_mux;
        if (off == OFF_MTIME_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: a register/decode vector table followed by
// hand-timed sequences for prescaling, carry, interrupt, collision and reset.
module tb_mmio_timer;

  localparam int          PRESCALE = 12;
  localparam logic [31:0] B        = 32'h0000_0420;

  logic        sysclk, rst, mem_en, mem_write, read_ack, irq;
  logic [31:0] addr, wdata, rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_timer #(.BASE(1056), .PRESCALE(PRESCALE)) dut (
    .clk(sysclk), .rst(rst), .mem_en(mem_en), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .read_ack(read_ack), .irq(irq)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_ack;
    logic        chk_data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic ack, input logic cd, input logic [31:0] e, input string n);
    vec_t v;
    v.is_wr = w; v.a = a; v.d = d; v.exp_ack = ack; v.chk_data = cd; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // All bus tasks are entered at a falling edge and return at a falling edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    mem_en = 1'b1; mem_write = 1'b1; addr = a; wdata = d;
    @(negedge sysclk);
    mem_en = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ack);
    mem_en = 1'b1; mem_write = 1'b0; addr = a;
    @(negedge sysclk);
    mem_en = 1'b0;
    d = rdata; ack = read_ack;
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string n);
    logic [31:0] d;
    logic        ack;
    bus_rd(a, d, ack);
    check({n, " ack"}, {31'd0, ack}, 32'd1);
    check(n, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        ack;

    rst = 1'b1; mem_en = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    @(negedge sysclk);
    check("reset rdata", rdata, 32'd0);
    check("reset ack", {31'd0, read_ack}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // ---------------- register / decode table (en = 0, nothing counts) -------
    add(0, B+32'h08, 0, 1, 1, 32'hFFFF_FFFF, "cmp_lo reset");
    add(0, B+32'h0C, 0, 1, 1, 32'hFFFF_FFFF, "cmp_hi reset");
    add(0, B+32'h10, 0, 1, 1, 32'h0, "ctrl reset");
    add(0, B+32'h14, 0, 1, 1, 32'h0, "status reset");
    add(0, B+32'h00, 0, 1, 1, 32'h0, "mtime_lo reset");
    add(1, B+32'h08, 32'h1234_5678, 0, 0, 0, "");
    add(0, B+32'h08, 0, 1, 1, 32'h1234_5678, "cmp_lo rw");
    add(0, B+32'h0B, 0, 1, 1, 32'h1234_5678, "byte bits ignored");
    add(1, B+32'h0C, 32'hDEAD_BEEF, 0, 0, 0, "");
    add(0, B+32'h0C, 0, 1, 1, 32'hDEAD_BEEF, "cmp_hi rw");
    add(1, B+32'h10, 32'hFFFF_FFFE, 0, 0, 0, "");
    add(0, B+32'h10, 0, 1, 1, 32'h0000_0002, "ctrl mask");
    add(1, B+32'h10, 32'h0, 0, 0, 0, "");
    add(1, B+32'h00, 32'hCAFE_F00D, 0, 0, 0, "");
    add(0, B+32'h00, 0, 1, 1, 32'hCAFE_F00D, "mtime_lo rw");
    add(1, B+32'h04, 32'h0000_0055, 0, 0, 0, "");
    add(0, B+32'h04, 0, 1, 1, 32'h0, "hi stale shadow");
    add(0, B+32'h00, 0, 1, 1, 32'hCAFE_F00D, "mtime_lo again");
    add(0, B+32'h04, 0, 1, 1, 32'h0000_0055, "hi fresh shadow");
    add(0, B+32'h18, 0, 1, 1, 32'h0, "off6 reads 0");
    add(1, B+32'h1C, 32'h1234_5678, 0, 0, 0, "");
    add(0, B+32'h1C, 0, 1, 1, 32'h0, "off7 reads 0");
    add(0, B-32'h4, 0, 0, 0, 0, "below base no ack");
    add(0, B+32'h20, 0, 0, 0, 0, "above base no ack");
    add(1, B+32'h20, 32'h0000_0007, 0, 0, 0, "");
    add(1, B-32'h18, 32'h0000_0001, 0, 0, 0, "");
    add(0, B+32'h00, 0, 1, 1, 32'hCAFE_F00D, "outside write ignored lo");
    add(0, B+32'h08, 0, 1, 1, 32'h1234_5678, "outside write ignored cmp");
    add(0, B+32'h14, 0, 1, 1, 32'h0, "status still clear");

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        bus_wr(tbl[i].a, tbl[i].d);
      end else begin
        bus_rd(tbl[i].a, d, ack);
        check({tbl[i].name, " ack"}, {31'd0, ack}, {31'd0, tbl[i].exp_ack});
        if (tbl[i].chk_data) check(tbl[i].name, d, tbl[i].exp);
        idle(1);
        check({tbl[i].name, " ack drop"}, {31'd0, read_ack}, 32'd0);
      end
    end

    // ---------------- reset mid-count with a read in flight -----------------
    do_reset();
    bus_wr(B+32'h0C, 32'h0);
    bus_wr(B+32'h08, 32'h2);
    bus_wr(B+32'h10, 32'h3);
    idle(40);
    check("irq before reset", {31'd0, irq}, 32'd1);
    mem_en = 1'b1; mem_write = 1'b0; addr = B;
    @(posedge sysclk);
    #1;
    check("ack before cut", {31'd0, read_ack}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async rst rdata", rdata, 32'd0);
    check("async rst ack", {31'd0, read_ack}, 32'd0);
    check("async rst irq", {31'd0, irq}, 32'd0);
    mem_en = 1'b0;
    @(negedge sysclk);
    rst = 1'b0;
    rd_check(B+32'h08, 32'hFFFF_FFFF, "post-rst cmp_lo");
    check("post-rst ack one cycle", {31'd0, read_ack}, 32'd1);
    idle(1);
    check("post-rst ack drop", {31'd0, read_ack}, 32'd0);
    rd_check(B+32'h00, 32'h0, "post-rst mtime");

    // ---------------- prescale count ----------------------------------------
    do_reset();
    bus_wr(B+32'h10, 32'h1);
    idle(10 * PRESCALE);
    rd_check(B+32'h00, 32'd10, "prescale 10 ticks");

    // ---------------- carry and atomic read ---------------------------------
    do_reset();
    bus_wr(B+32'h04, 32'h0);
    bus_wr(B+32'h00, 32'hFFFF_FFFF);
    bus_wr(B+32'h10, 32'h1);
    idle(15);
    rd_check(B+32'h00, 32'h0, "carry lo");
    bus_wr(B+32'h04, 32'h0000_ABCD);
    rd_check(B+32'h04, 32'h1, "carry hi shadow");
    rd_check(B+32'h00, 32'h0, "lo after hi write");
    rd_check(B+32'h04, 32'h0000_ABCD, "hi after relatch");

    // ---------------- interrupt ---------------------------------------------
    do_reset();
    bus_wr(B+32'h0C, 32'h0);
    bus_wr(B+32'h08, 32'h5);
    bus_wr(B+32'h10, 32'h3);
    idle(5 * PRESCALE);
    check("irq not yet at match edge", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq one cycle after match", {31'd0, irq}, 32'd1);
    bus_wr(B+32'h14, 32'h1);
    check("clear loses to set", {31'd0, irq}, 32'd1);
    rd_check(B+32'h14, 32'h1, "status pending");
    bus_wr(B+32'h10, 32'h1);
    check("irq masked", {31'd0, irq}, 32'd0);
    bus_wr(B+32'h10, 32'h3);
    bus_wr(B+32'h0C, 32'hFFFF_FFFF);
    bus_wr(B+32'h08, 32'hFFFF_FFFF);
    check("cmp raise keeps pending", {31'd0, irq}, 32'd1);
    bus_wr(B+32'h14, 32'h0);
    check("status write 0 no effect", {31'd0, irq}, 32'd1);
    bus_wr(B+32'h14, 32'h1);
    check("irq cleared", {31'd0, irq}, 32'd0);
    rd_check(B+32'h14, 32'h0, "status cleared");

    // ---------------- write vs rollover collision ---------------------------
    do_reset();
    bus_wr(B+32'h10, 32'h1);
    idle(2 * PRESCALE - 1);
    bus_wr(B+32'h00, 32'd100);
    idle(PRESCALE - 2);
    rd_check(B+32'h00, 32'd100, "collision write wins");
    rd_check(B+32'h00, 32'd100, "no tick before prescale");
    rd_check(B+32'h00, 32'd101, "tick prescale after write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
